// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory bus between the fetch stage and a
// synchronous-read instruction memory.
//   imem_addr : fetch address (master -> memory)
//   imem_rd   : read enable   (master -> memory)
//   imem_data : returned word, valid one cycle after addr/rd (memory -> master)
interface instr_fetch_if #(
   parameter int PC_W = 8
);
   logic [PC_W-1:0] imem_addr;
   logic            imem_rd;
   logic [15:0]     imem_data;

   modport master (output imem_addr, output imem_rd, input imem_data);
   modport slave  (input imem_addr, input imem_rd, output imem_data);
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage of the RNBIP-2 pipeline. Owns the PC, drives a
// synchronous-read instruction memory and presents one 16-bit segment per
// cycle with its next-PC. Redirects (L_PC) squash the presented word to NOP.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   stall        : downstream hold; PC frozen, presented segment stable
//   L_PC         : one-cycle redirect strobe, pc_target is the new PC
//   bus          : instruction memory bus (imem_addr/imem_rd/imem_data)
//   segment      : instruction to downstream, 16'h0000 when not valid
//   NPC_out      : presented address + 1 (mod 2^PC_W)
//   seg_valid    : segment is a real, non-squashed instruction
//   flush        : mirrors L_PC, squashes the downstream latch
//   fetch_count  : instructions accepted downstream (wraps)
module instr_fetch #(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              CNT_W    = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               L_PC,
   input  logic [PC_W-1:0]    pc_target,
   instr_fetch_if.master      bus,
   output logic [15:0]        segment,
   output logic [PC_W-1:0]    NPC_out,
   output logic               seg_valid,
   output logic               flush,
   output logic [CNT_W-1:0]   fetch_count
);

   typedef enum logic [1:0] {BOOT, RUN, HOLD, REDIR} state_t;

   state_t          state, state_nxt;
   logic [PC_W-1:0] pc, pc_nxt;
   logic [PC_W-1:0] req_pc, req_pc_nxt;
   logic            req_valid, req_valid_nxt;

   // Outputs are forced to their reset values while rst_n is low so that the
   // first reset cycle already shows NOP, not the word left in flight.
   assign seg_valid = rst_n & req_valid & ~L_PC;
   assign segment   = seg_valid ? bus.imem_data : 16'h0000;
   assign NPC_out   = rst_n ? req_pc + PC_W'(1) : RESET_PC + PC_W'(1);
   assign flush     = rst_n & L_PC;
   assign bus.imem_rd = rst_n;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= BOOT;
         pc          <= RESET_PC;
         req_pc      <= RESET_PC;
         req_valid   <= 1'b0;
         fetch_count <= '0;
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         req_pc    <= req_pc_nxt;
         req_valid <= req_valid_nxt;
         if (seg_valid && !stall)
            fetch_count <= fetch_count + CNT_W'(1);
      end
   end

   always_comb begin
      state_nxt     = state;
      pc_nxt        = pc;
      req_pc_nxt    = req_pc;
      req_valid_nxt = req_valid;
      bus.imem_addr = pc;
      if (L_PC) begin
         // Target goes straight to the memory so it returns next cycle.
         bus.imem_addr = pc_target;
         req_pc_nxt    = pc_target;
         pc_nxt        = pc_target + PC_W'(1);
         req_valid_nxt = 1'b1;
         state_nxt     = REDIR;
      end else if (stall && state != BOOT) begin
         // Re-read the outstanding address so the returned word stays put.
         bus.imem_addr = req_pc;
         state_nxt     = HOLD;
      end else begin
         bus.imem_addr = pc;
         req_pc_nxt    = pc;
         pc_nxt        = pc + PC_W'(1);
         req_valid_nxt = 1'b1;
         state_nxt     = RUN;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
   localparam int        PC_W   = 8;
   localparam int        CNT_W  = 16;
   localparam logic [7:0] RST_PC = 8'h00;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              stall = 1'b0;
   logic              L_PC = 1'b0;
   logic [PC_W-1:0]   pc_target = '0;
   logic [15:0]       segment;
   logic [PC_W-1:0]   NPC_out;
   logic              seg_valid;
   logic              flush;
   logic [CNT_W-1:0]  fetch_count;

   instr_fetch_if #(.PC_W(PC_W)) bus ();

   instr_fetch #(.PC_W(PC_W), .RESET_PC(RST_PC), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .L_PC(L_PC),
      .pc_target(pc_target), .bus(bus.master), .segment(segment),
      .NPC_out(NPC_out), .seg_valid(seg_valid), .flush(flush),
      .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   // Synchronous-read instruction memory.
   logic [15:0] mem [256];
   always @(posedge clk) if (bus.imem_rd) bus.imem_data <= mem[bus.imem_addr];

   int n_chk = 0;
   int n_fail = 0;

   // Transaction-level reference: which address is presented, which is fetched next.
   bit          m_known = 1'b0;
   bit          m_valid;
   bit          m_boot;
   logic [7:0]  m_addr, m_next;
   logic [15:0] m_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      bit         ev;
      logic [7:0] npc, eaddr;
      ev  = m_valid && !L_PC && rst_n;
      npc = rst_n ? m_addr + 8'd1 : RST_PC + 8'd1;
      eaddr = L_PC ? pc_target : ((stall && !m_boot) ? m_addr : m_next);
      chk("seg_valid", seg_valid, ev);
      chk("segment", segment, ev ? mem[m_addr] : 16'h0000);
      chk("npc", NPC_out, npc);
      chk("flush", flush, L_PC && rst_n);
      chk("fetch_count", fetch_count, m_cnt);
      chk("imem_rd", bus.imem_rd, rst_n);
      if (rst_n) chk("imem_addr", bus.imem_addr, eaddr);
   endtask

   task automatic drive(input bit r, input bit s, input bit l, input logic [7:0] t);
      rst_n = r; stall = s; L_PC = l; pc_target = t;
      @(negedge clk);
      if (m_known) check_model();
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst_n) begin
         m_known = 1'b1; m_valid = 1'b0; m_boot = 1'b1;
         m_addr = RST_PC; m_next = RST_PC; m_cnt = '0;
      end else if (m_known) begin
         if (m_valid && !L_PC && !stall) m_cnt = m_cnt + 16'd1;
         if (L_PC) begin
            m_valid = 1'b1; m_addr = pc_target; m_next = pc_target + 8'd1;
         end else if (!(stall && !m_boot)) begin
            m_valid = 1'b1; m_addr = m_next; m_next = m_next + 8'd1;
         end
         m_boot = 1'b0;
      end
      #1;
   endtask

   task automatic step(input bit r, input bit s, input bit l, input logic [7:0] t);
      drive(r, s, l, t);
      tick();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = {8'(8'h10 + i), 8'(i)};
      #1;
      // Reset and sequential fetch
      step(0, 0, 0, 0);
      drive(0, 0, 0, 0);
      chk("rst_count", fetch_count, 16'd0);
      chk("rst_npc", NPC_out, 8'h01);
      tick();
      drive(1, 0, 0, 0);
      chk("boot_addr", bus.imem_addr, 8'h00);
      chk("boot_valid", seg_valid, 1'b0);
      tick();
      drive(1, 0, 0, 0);
      chk("first_seg", segment, 16'h1000);
      chk("first_npc", NPC_out, 8'h01);
      chk("first_valid", seg_valid, 1'b1);
      tick();
      drive(1, 0, 0, 0);
      chk("seq1", segment, 16'h1101);
      tick();
      drive(1, 0, 0, 0);
      chk("seq2", segment, 16'h1202);
      chk("seq2_count", fetch_count, 16'd2);
      tick();
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      // Stall for 3 cycles on addr 5
      for (int k = 0; k < 3; k++) begin
         drive(1, 1, 0, 0);
         chk("stall_seg", segment, 16'h1505);
         chk("stall_npc", NPC_out, 8'h06);
         chk("stall_addr", bus.imem_addr, 8'h05);
         chk("stall_count", fetch_count, 16'd5);
         tick();
      end
      drive(1, 0, 0, 0);
      chk("release_seg", segment, 16'h1505);
      tick();
      drive(1, 0, 0, 0);
      chk("after_stall", segment, 16'h1606);
      chk("after_count", fetch_count, 16'd6);
      tick();
      // Redirect to 3, then redirect to 0x40 while addr 3 is presented
      step(1, 0, 1, 8'h03);
      drive(1, 0, 1, 8'h40);
      chk("redir_flush", flush, 1'b1);
      chk("redir_seg", segment, 16'h0000);
      chk("redir_valid", seg_valid, 1'b0);
      chk("redir_addr", bus.imem_addr, 8'h40);
      tick();
      drive(1, 0, 0, 0);
      chk("target_seg", segment, 16'h5040);
      chk("target_npc", NPC_out, 8'h41);
      tick();
      // L_PC beats stall
      drive(1, 1, 1, 8'h80);
      chk("ls_addr", bus.imem_addr, 8'h80);
      chk("ls_flush", flush, 1'b1);
      tick();
      drive(1, 0, 0, 0);
      chk("ls_seg", segment, 16'h9080);
      tick();
      // Wrap
      step(1, 0, 1, 8'hFE);
      drive(1, 0, 0, 0);
      chk("wrap_fe", segment, 16'h0EFE);
      tick();
      drive(1, 0, 0, 0);
      chk("wrap_ff", segment, 16'h0FFF);
      chk("wrap_npc", NPC_out, 8'h00);
      tick();
      drive(1, 0, 0, 0);
      chk("wrap_00", segment, 16'h1000);
      tick();
      // Back-to-back redirects: last one wins
      step(1, 0, 1, 8'h20);
      step(1, 0, 1, 8'h30);
      drive(1, 0, 0, 0);
      chk("b2b_seg", segment, 16'h4030);
      tick();
      // Reset during HOLD
      step(1, 1, 0, 0);
      step(1, 1, 0, 0);
      step(0, 1, 0, 0);
      drive(0, 0, 0, 0);
      chk("hrst_valid", seg_valid, 1'b0);
      chk("hrst_count", fetch_count, 16'd0);
      chk("hrst_npc", NPC_out, 8'h01);
      tick();
      drive(1, 0, 0, 0);
      chk("hrst_boot", bus.imem_addr, RST_PC);
      tick();
      drive(1, 0, 0, 0);
      chk("hrst_seg", segment, 16'h1000);
      tick();
      // Random phase with fresh random memory contents
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      step(0, 0, 0, 0);
      for (int n = 0; n < 600; n++) begin
         step(($urandom % 50) != 0, ($urandom % 10) < 3, ($urandom % 10) == 0,
              8'($urandom));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
